// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: one access per cycle,
// burst-limited round-robin by default, fixed port-0 priority with MEMORY_ARB_FIXED_PRIO_EN.
module memory_arbiter #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [AWIDTH-1:0] p0_addr,
  input  logic [DWIDTH-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DWIDTH-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [AWIDTH-1:0] p1_addr,
  input  logic [DWIDTH-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DWIDTH-1:0] p1_rdata,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] rpend;

  assign req = {p1_req, p0_req};

`ifdef MEMORY_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (p0_req)      gnt = 2'b01;
      else if (p1_req) gnt = 2'b10;
    end
  end
`else
  localparam int CW = $clog2(BURST + 1);

  logic          last;
  logic [CW-1:0] cnt;

  // Under contention the previous owner keeps the RAM until it has used BURST slots.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ((cnt < CW'(BURST)) ^ last) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b0;
      cnt  <= '0;
    end else if (|gnt) begin
      if (gnt[1] == last) begin
        if (cnt < CW'(BURST)) cnt <= cnt + CW'(1);
      end else begin
        last <= gnt[1];
        cnt  <= CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end
`endif

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  always_comb begin
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_wr    = p0_wr;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (gnt[1]) begin
      mem_wr    = p1_wr;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // Read-return tag: one cycle, aligned with the RAM's registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) rpend <= '0;
    else        rpend <= gnt & ~{p1_wr, p0_wr};
  end

  // Gating with rst_n drops a return whose read was granted just before reset.
  assign p0_rvalid = rpend[0] & rst_n;
  assign p1_rvalid = rpend[1] & rst_n;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: vector table, hand sequences, random traffic vs. a history-based model.
module tb_memory_arbiter;
  localparam int AW = 8, DW = 32, BURST = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic p0_req = 0, p0_wr = 0, p1_req = 0, p1_wr = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_wr;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ram [256];

  int checks = 0, errors = 0;

  memory_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: grant history per cycle (-1 idle), memory image, pending returns.
  int hist[$];
  bit pv[2];
  logic [DW-1:0] pd[2];
  logic [DW-1:0] mm[256];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int exp_grant(input logic r0, input logic r1);
    int pref, streak;
    pref = 0;
    streak = 0;
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef MEMORY_ARB_FIXED_PRIO_EN
    return 0;
`else
    for (int i = hist.size() - 1; i >= 0; i--)
      if (hist[i] >= 0) begin pref = hist[i]; break; end
    for (int i = hist.size() - 1; i >= 0 && hist[i] == pref; i--) streak++;
    return (streak < BURST) ? pref : 1 - pref;
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    pv[0] = 0;
    pv[1] = 0;
  endtask

  // Called just after a rising edge; drives one cycle, checks at the falling edge.
  task automatic cyc(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     output logic og0, og1, ov0, ov1, output logic [DW-1:0] ord0, ord1);
    int g;
    logic gw;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    p0_req = r0; p0_wr = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_wr = w1; p1_addr = a1; p1_wdata = d1;
    g  = exp_grant(r0, r1);
    gw = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
    ga = (g == 0) ? a0 : (g == 1) ? a1 : '0;
    gd = (g == 0) ? d0 : d1;
    @(negedge clk);
    og0 = p0_gnt; og1 = p1_gnt; ov0 = p0_rvalid; ov1 = p1_rvalid;
    ord0 = p0_rdata; ord1 = p1_rdata;
    chk("m_gnt0", p0_gnt, g == 0);
    chk("m_gnt1", p1_gnt, g == 1);
    chk("m_mem_wr", mem_wr, gw);
    chk("m_mem_addr", mem_addr, ga);
    if (gw) chk("m_mem_wdata", mem_wdata, gd);
    chk("m_rvalid0", p0_rvalid, pv[0]);
    chk("m_rvalid1", p1_rvalid, pv[1]);
    if (pv[0]) chk("m_rdata0", p0_rdata, pd[0]);
    if (pv[1]) chk("m_rdata1", p1_rdata, pd[1]);
    @(posedge clk);
    pv[0] = (g == 0) && !w0;
    pv[1] = (g == 1) && !w1;
    if (g >= 0 && !gw) pd[g] = mm[ga];
    if (gw) mm[ga] = gd;
    hist.push_back(g);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    p0_req = 1; p1_req = 1; p0_wr = 0; p1_wr = 0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_gnt", {p1_gnt, p0_gnt}, 2'b00);
      chk("rst_mem_wr", mem_wr, 1'b0);
      chk("rst_rvalid", {p1_rvalid, p0_rvalid}, 2'b00);
      @(posedge clk);
      #1;
    end
    rst_n = 1;
    p0_req = 0; p1_req = 0;
    model_reset();
  endtask

  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic g0, g1, v0, v1; logic [DW-1:0] rd;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic g0, g1, v0, v1;
    logic [DW-1:0] rd0, rd1;
    logic [AW-1:0] a;
    tbl[0] = '{1, 1, 8'h12, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0, 1, 0, 0, 0, 32'h0};
    tbl[1] = '{1, 0, 8'h12, 32'h0,        0, 0, 8'h00, 32'h0, 1, 0, 0, 0, 32'h0};
    tbl[2] = '{0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0, 0, 0, 1, 0, 32'hDEADBEEF};
    tbl[3] = '{0, 0, 8'h00, 32'h0,        1, 1, 8'h34, 32'hCAFEF00D, 0, 1, 0, 0, 32'h0};
    tbl[4] = '{0, 0, 8'h00, 32'h0,        1, 0, 8'h34, 32'h0, 0, 1, 0, 0, 32'h0};
    tbl[5] = '{1, 0, 8'h34, 32'h0,        0, 0, 8'h00, 32'h0, 1, 0, 0, 1, 32'hCAFEF00D};
    tbl[6] = '{0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0, 0, 0, 1, 0, 32'hCAFEF00D};
    tbl[7] = '{1, 1, 8'h12, 32'h11111111, 0, 0, 8'h00, 32'h0, 1, 0, 0, 0, 32'h0};
    tbl[8] = '{0, 0, 8'h00, 32'h0,        1, 0, 8'h12, 32'h0, 0, 1, 0, 0, 32'h0};
    tbl[9] = '{0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0, 0, 0, 0, 1, 32'h11111111};
    model_reset();

    // Reset held with both ports requesting, then port 0 wins first.
    @(posedge clk); #1;
    do_reset(3);
    cyc(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, g0, g1, v0, v1, rd0, rd1);
    chk("first_after_reset", {g1, g0}, 2'b01);
    do_reset(1);

    foreach (tbl[i]) begin
      cyc(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1,
          g0, g1, v0, v1, rd0, rd1);
      chk($sformatf("vec%0d_gnt", i), {g1, g0}, {tbl[i].g1, tbl[i].g0});
      chk($sformatf("vec%0d_rvalid", i), {v1, v0}, {tbl[i].v1, tbl[i].v0});
      if (tbl[i].v0) chk($sformatf("vec%0d_rdata0", i), rd0, tbl[i].rd);
      if (tbl[i].v1) chk($sformatf("vec%0d_rdata1", i), rd1, tbl[i].rd);
    end

    // Continuous contention from a fresh reset.
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 8'h12, 0, 1, 0, 8'h34, 0, g0, g1, v0, v1, rd0, rd1);
`ifdef MEMORY_ARB_FIXED_PRIO_EN
      chk($sformatf("contend%0d", i), {g1, g0}, 2'b01);
`else
      chk($sformatf("contend%0d", i), {g1, g0}, ((i / BURST) % 2) ? 2'b10 : 2'b01);
`endif
    end
    cyc(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, g0, g1, v0, v1, rd0, rd1);

    // Lone requester runs past BURST, then yields when port 0 joins.
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 8'h00, 0, 1, 0, 8'h34, 0, g0, g1, v0, v1, rd0, rd1);
      chk($sformatf("lone%0d", i), {g1, g0}, 2'b10);
    end
    cyc(1, 0, 8'h12, 0, 1, 0, 8'h34, 0, g0, g1, v0, v1, rd0, rd1);
    chk("lone_then_both", {g1, g0}, 2'b01);

    // Reset arriving right after a read grant drops the return.
    cyc(1, 0, 8'h12, 0, 0, 0, 8'h00, 0, g0, g1, v0, v1, rd0, rd1);
    chk("midrd_granted", g0, 1'b1);
    rst_n = 0; p0_req = 0; p1_req = 0;
    @(negedge clk);
    chk("midrd_rvalid0", p0_rvalid, 1'b0);
    chk("midrd_rvalid1", p1_rvalid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();

`ifdef MEMORY_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 8'h12, 0, 1, 0, 8'h34, 0, g0, g1, v0, v1, rd0, rd1);
      chk($sformatf("fixed%0d", i), {g1, g0}, 2'b01);
    end
    cyc(0, 0, 8'h00, 0, 1, 0, 8'h34, 0, g0, g1, v0, v1, rd0, rd1);
    chk("fixed_p1_after_drop", {g1, g0}, 2'b10);
`endif

    // Seed addresses 0..15, then random mixed traffic.
    for (int i = 0; i < 16; i++) begin
      a = AW'(i);
      if (i % 2 == 0) cyc(1, 1, a, $urandom, 0, 0, 8'h00, 0, g0, g1, v0, v1, rd0, rd1);
      else            cyc(0, 0, 8'h00, 0, 1, 1, a, $urandom, g0, g1, v0, v1, rd0, rd1);
    end
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), $urandom,
          g0, g1, v0, v1, rd0, rd1);
    end
    cyc(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, g0, g1, v0, v1, rd0, rd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter that shares one single-port synchronous RAM, of the same kind as the project's `memory2` block, between two masters. The RAM performs one write or one read per cycle and returns read data one cycle after the read is issued. This block sits between the masters and the RAM. It grants at most one access per cycle, bounds consecutive grants to one master with a burst counter, and routes the returned read data back to the master that issued the read.

## Interface
Parameters:
- `AWIDTH`, 8, address width, matching the RAM.
- `DWIDTH`, 32, data width, matching the RAM.
- `BURST`, 4, maximum consecutive grants to one port while the other port is requesting; legal range ≥1.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `p0_req` in 1: port 0 access request, level, held until granted.
- `p0_wr` in 1: 1 = write, 0 = read.
- `p0_addr` in AWIDTH: port 0 access address.
- `p0_wdata` in DWIDTH: port 0 write data.
- `p0_gnt` out 1: combinational grant; access is accepted in any cycle with `p0_req` && `p0_gnt`.
- `p0_rvalid` out 1: registered; `p0_rdata` is valid this cycle.
- `p0_rdata` out DWIDTH: equal to `mem_rdata`.
- `p1_*`: identical set of seven signals for port 1.
- `mem_wr` out 1: write strobe to the RAM.
- `mem_addr` out AWIDTH: RAM address.
- `mem_wdata` out DWIDTH: RAM write data.
- `mem_rdata` in DWIDTH: RAM registered read data.

## Operation
- State registers:
  - `last`: last granted port, 1 bit, reset 0.
  - `cnt`: consecutive grants to `last`, width $clog2(BURST+1), reset 0, saturates at BURST.
  - `rpend[1:0]`: read-return tags, reset 0.
- Grant decision, combinational, each cycle:
  - No request: no grant.
  - Exactly one port requesting: that port is granted.
  - Both ports requesting: `last` is granted if `cnt < BURST`; otherwise the other port is granted.
  - `rst_n` = 0 forces both grants to 0.
- Counter update on a grant to port p:
  - p == `last`: `cnt` ← min(`cnt`+1, BURST).
  - Otherwise: `last` ← p and `cnt` ← 1.
- Counter update on a cycle with no grant: `cnt` ← 0; `last` is held.
- RAM drive:
  - On a grant, `mem_wr`, `mem_addr` and `mem_wdata` are taken from the granted port.
  - With no grant, `mem_wr` = 0 and `mem_addr` = 0. The RAM's idle read is ignored.
- Read return:
  - A granted read on port p sets `rpend[p]` = 1 for the next cycle only.
  - `pX_rvalid` = `rpend[X]`.
  - `pX_rdata` = `mem_rdata` on both ports at all times; it is meaningful only while `pX_rvalid` = 1.
- A granted write produces no rvalid.
- Reads and writes may interleave back-to-back on either port with no bubble.
- Address and data widths pass through unchanged. No address checking is performed.

## Timing
- Reset values: `pX_gnt` = 0, `pX_rvalid` = 0, `mem_wr` = 0, `mem_addr` = 0, `last` = 0, `cnt` = 0, `rpend` = 0.
- Grant latency: 0 cycles, same cycle as the request.
- Throughput: one access per cycle.
- Read latency: the read is granted in cycle N; `pX_rvalid` = 1 and data is valid in cycle N+1.
- Write: the RAM is updated at the end of the granted cycle. A read of the same address granted in N+1 returns the new data in N+2.
- Arbitration boundaries:
  - With both ports requesting continuously, the grant sequence is BURST×`last`, then BURST×other, and so on.
  - A lone requester is never starved by the counter; it may exceed BURST.
- Reset mid-operation: an outstanding read return is discarded, so `rvalid` is 0 in the cycle after reset asserts. An access presented while `rst_n` = 0 is not granted.

## Configuration
- `MEMORY_ARB_FIXED_PRIO_EN`, defined: fixed priority.
  - Port 0 wins whenever both ports request.
  - `last` and `cnt` are not implemented.
  - BURST is unused.
- `MEMORY_ARB_FIXED_PRIO_EN`, undefined (default): the burst-limited round-robin described above.

## Test plan
- Reset/idle: hold `rst_n` = 0 for 3 cycles with `p0_req` = `p1_req` = 1 → no grant, `mem_wr` = 0, both `rvalid` = 0. After release, port 0 is granted first.
- Single-port write/read: p0 writes 0xDEADBEEF to 0x12, then reads 0x12 on the next cycle → `p0_rvalid` = 1 one cycle after the read grant, `p0_rdata` = 0xDEADBEEF, `p1_rvalid` = 0.
- Contention, BURST = 4, default build: both ports request reads continuously for 16 cycles → grants P0×4, P1×4, P0×4, P1×4. Each `rvalid` lands on the correct port one cycle after its grant.
- Lone requester: p1 alone requests for 10 cycles → granted all 10. Then p0 also requests with `cnt` = 4 → p0 is granted next.
- Reset mid-read: read granted in cycle N, `rst_n` = 0 in cycle N+1 → `p0_rvalid` = 0 in N+1.
- `MEMORY_ARB_FIXED_PRIO_EN` build: both ports request for 8 cycles → p0 granted all 8, p1 granted only after `p0_req` drops.
